// File: rtl/md_pkg.sv
// md_pkg: opcode, state and sizing definitions shared by the multiply/divide unit.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a; the unit signals occupancy through start/busy.
//
// Build option: MDU_MADD_EN enables the MADD/MADDU accumulate opcodes.
// Without it, opcodes 7/8 decode as NONE.
package md_pkg;

  localparam int MD_OP_W  = 4;
  localparam int MD_CNT_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8
  } md_op_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  // Opcodes that occupy the unit for several cycles.
  function automatic logic md_is_start(input logic [MD_OP_W-1:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU);
`endif
    return r;
  endfunction

  // Multiply-class opcodes take the MULT_CYCLES latency; everything else that
  // starts is a divide.
  function automatic logic md_is_mult(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) || (op == MD_MADDU);
  endfunction

endpackage

// File: rtl/md_if.sv
// md_if: E-stage connection between the pipeline and the multiply/divide unit.
// Latency: n/a (wires only).
// Backpressure: start/busy tell the hazard logic to hold MD-class instructions in D.
//
// master (pipeline): drives md_op, rs_val, rt_val, rd_sel; sees start, busy, hi, lo, rd_data.
// slave  (md_unit) : the reverse.
interface md_if;
  import md_pkg::*;

  logic [MD_OP_W-1:0] md_op;
  logic [31:0]        rs_val;
  logic [31:0]        rt_val;
  logic               rd_sel;
  logic               start;
  logic               busy;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [31:0]        rd_data;

  modport master (
    output md_op, rs_val, rt_val, rd_sel,
    input  start, busy, hi, lo, rd_data
  );

  modport slave (
    input  md_op, rs_val, rt_val, rd_sel,
    output start, busy, hi, lo, rd_data
  );

endinterface

// File: rtl/md_alu.sv
// md_alu: combinational HI/LO result for a latched multiply/divide operation.
// Latency: 0 cycles (pure combinational; the caller decides when to commit).
// Backpressure: none; wr_en=0 means HI/LO must keep their old values.
//
// Ports: op (latched opcode), a/b (latched rs/rt), hi_old/lo_old (current HI/LO),
//        wr_en, hi_new, lo_new.
// Build option: MDU_MADD_EN adds the MADD/MADDU accumulate paths.
module md_alu
  import md_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  input  logic [31:0]        hi_old,
  input  logic [31:0]        lo_old,
  output logic               wr_en,
  output logic [31:0]        hi_new,
  output logic [31:0]        lo_new
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic               div_zero;

  // Explicit sign extension so the 64-bit product never depends on context sizing.
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'h0, a} * {32'h0, b};

  // Signed / and % truncate toward zero; remainder takes the dividend's sign.
  assign quo_s = $signed(a) / $signed(b);
  assign rem_s = $signed(a) % $signed(b);
  assign quo_u = a / b;
  assign rem_u = a % b;
  assign div_zero = (b == 32'h0);

  always_comb begin
    wr_en  = 1'b0;
    hi_new = hi_old;
    lo_new = lo_old;
    case (op)
      MD_MULT: begin
        wr_en            = 1'b1;
        {hi_new, lo_new} = $unsigned(prod_s);
      end
      MD_MULTU: begin
        wr_en            = 1'b1;
        {hi_new, lo_new} = prod_u;
      end
      MD_DIV: begin
        // A zero divisor leaves HI/LO untouched.
        if (!div_zero) begin
          wr_en  = 1'b1;
          lo_new = $unsigned(quo_s);
          hi_new = $unsigned(rem_s);
        end
      end
      MD_DIVU: begin
        if (!div_zero) begin
          wr_en  = 1'b1;
          lo_new = quo_u;
          hi_new = rem_u;
        end
      end
`ifdef MDU_MADD_EN
      // Accumulate against HI/LO as they stand at completion, wrapping mod 2^64.
      MD_MADD: begin
        wr_en            = 1'b1;
        {hi_new, lo_new} = {hi_old, lo_old} + $unsigned(prod_s);
      end
      MD_MADDU: begin
        wr_en            = 1'b1;
        {hi_new, lo_new} = {hi_old, lo_old} + prod_u;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning HI/LO, sequencing multi-cycle ops.
// Latency: MULT_CYCLES busy cycles for mult-class, DIV_CYCLES for div; mthi/mtlo write next edge.
// Backpressure: start (comb) and busy (registered) stall MD-class instructions in D.
//
// Ports: clk, reset (sync, active-high), md (md_if.slave: md_op, rs_val, rt_val, rd_sel in;
//        start, busy, hi, lo, rd_data out).
// Build option: MDU_MADD_EN enables MADD/MADDU; otherwise opcodes 7/8 behave as NONE.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,   // 1..15
  parameter int DIV_CYCLES  = 10   // 1..15
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  md
);

  md_state_t             state;
  logic [MD_CNT_W-1:0]   cnt;
  logic [MD_CNT_W-1:0]   cnt_init;
  logic [MD_OP_W-1:0]    op_q;
  logic [31:0]           a_q;
  logic [31:0]           b_q;
  logic [31:0]           hi_q;
  logic [31:0]           lo_q;
  logic                  alu_wr;
  logic [31:0]           alu_hi;
  logic [31:0]           alu_lo;

  assign md.start  = (state == MD_IDLE) && md_is_start(md.md_op);
  assign md.busy   = (state == MD_RUN);
  assign md.hi     = hi_q;
  assign md.lo     = lo_q;
  // No bypass: a same-cycle HI/LO write is not visible here.
  assign md.rd_data = md.rd_sel ? hi_q : lo_q;

  // Counter is loaded with N-1 so the op occupies exactly N RUN cycles.
  assign cnt_init = md_is_mult(md.md_op) ? MD_CNT_W'(MULT_CYCLES - 1)
                                         : MD_CNT_W'(DIV_CYCLES - 1);

  // Works only from latched operands so stale forwarding paths cannot leak in.
  md_alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_old (hi_q),
    .lo_old (lo_q),
    .wr_en  (alu_wr),
    .hi_new (alu_hi),
    .lo_new (alu_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      op_q  <= MD_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md.start) begin
            op_q  <= md.md_op;
            a_q   <= md.rs_val;
            b_q   <= md.rt_val;
            cnt   <= cnt_init;
            state <= MD_RUN;
          end else if (md.md_op == MD_MTHI) begin
            hi_q <= md.rs_val;
          end else if (md.md_op == MD_MTLO) begin
            lo_q <= md.rs_val;
          end
        end
        MD_RUN: begin
          // mthi/mtlo and new starts are ignored while running.
          if (cnt == '0) begin
            state <= MD_IDLE;
            if (alu_wr) begin
              hi_q <= alu_hi;
              lo_q <= alu_lo;
            end
          end else begin
            cnt <= cnt - MD_CNT_W'(1);
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against an arithmetic reference model.
// Latency: model tracks remaining busy cycles per op and commits HI/LO on the last one.
// Backpressure: model ignores starts and mthi/mtlo while an op is in flight.
module tb_md_unit;
  import md_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_if bus ();

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo;
  int          left;          // busy cycles still to come (0 = idle)
  logic [3:0]  p_op;
  logic [31:0] p_a, p_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit starts(input logic [3:0] op);
    bit r;
    r = (op >= 4'd1) && (op <= 4'd4);
`ifdef MDU_MADD_EN
    r = r || (op == 4'd7) || (op == 4'd8);
`endif
    return r;
  endfunction

  // Architectural effect of a finished op on HI/LO.
  task automatic model_complete();
    int              sa, sb;
    longint          sp;
    longint unsigned up, acc;
    logic [63:0]     r64;
    sa = p_a;
    sb = p_b;
    sp = longint'(sa) * longint'(sb);
    up = longint'({32'h0, p_a}) * longint'({32'h0, p_b});
    case (p_op)
      4'd1: begin r64 = sp; m_hi = r64[63:32]; m_lo = r64[31:0]; end
      4'd2: begin r64 = up; m_hi = r64[63:32]; m_lo = r64[31:0]; end
      4'd3: if (sb != 0) begin m_lo = sa / sb; m_hi = sa % sb; end
      4'd4: if (p_b != 0) begin m_lo = p_a / p_b; m_hi = p_a % p_b; end
      4'd7: begin acc = {m_hi, m_lo} + sp; r64 = acc; m_hi = r64[63:32]; m_lo = r64[31:0]; end
      4'd8: begin acc = {m_hi, m_lo} + up; r64 = acc; m_hi = r64[63:32]; m_lo = r64[31:0]; end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_hi = '0;
    m_lo = '0;
    left = 0;
  endtask

  // One clock: drive inputs, check outputs against model, clock, advance model.
  task automatic cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sel);
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.rd_sel = sel;
    #1;
    check("start", bus.start, (left == 0) && starts(op));
    check("busy", bus.busy, left > 0);
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
    check("rd_data", bus.rd_data, sel ? m_hi : m_lo);
    @(posedge clk);
    if (left > 0) begin
      if (left == 1) model_complete();
      left--;
    end else if (starts(op)) begin
      p_op = op;
      p_a  = a;
      p_b  = b;
      left = (op == 4'd1 || op == 4'd2 || op == 4'd7 || op == 4'd8) ? MULT_N : DIV_N;
    end else if (op == 4'd5) begin
      m_hi = a;
    end else if (op == 4'd6) begin
      m_lo = a;
    end
    #1;
  endtask

  // Issue one op, then idle until busy drops (bounded); checks the busy length.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_n);
    int n;
    n = 0;
    cycle(op, a, b, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (bus.busy !== 1'b1) break;
      n++;
      cycle(MD_NONE, 32'h0, 32'h0, 1'($urandom_range(0, 1)));
    end
    check("busy_len", n, exp_n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          r;

    reset      = 1'b1;
    bus.md_op  = MD_NONE;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.rd_sel = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    reset = 1'b0;

    // Signed and unsigned multiply of -2 * 3
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, MULT_N);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, MULT_N);
    check("multu_hi", bus.hi, 32'h0000_0002);
    check("multu_lo", bus.lo, 32'hFFFF_FFFA);

    // Division: -7/2 and 7/2
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, DIV_N);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(MD_DIVU, 32'd7, 32'd2, DIV_N);
    check("divu_lo", bus.lo, 32'd3);
    check("divu_hi", bus.hi, 32'd1);

    // Divide by zero keeps HI/LO
    cycle(MD_MTHI, 32'h11, 32'h0, 1'b1);
    cycle(MD_MTLO, 32'h22, 32'h0, 1'b0);
    run_op(MD_DIV, 32'd5, 32'd0, DIV_N);
    check("div0_hi", bus.hi, 32'h11);
    check("div0_lo", bus.lo, 32'h22);

    // mthi in idle, mtlo during a multiply
    cycle(MD_MTHI, 32'hABCD, 32'h0, 1'b1);
    check("mthi_hi", bus.hi, 32'hABCD);
    check("mthi_busy", bus.busy, 1'b0);
    cycle(MD_MULT, 32'd6, 32'd7, 1'b0);
    cycle(MD_NONE, 32'h0, 32'h0, 1'b0);
    cycle(MD_MTLO, 32'hDEAD, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (bus.busy !== 1'b1) break;
      cycle(MD_NONE, 32'h0, 32'h0, 1'b0);
    end
    check("mtlo_run_lo", bus.lo, 32'd42);
    check("mtlo_run_hi", bus.hi, 32'd0);

    // MADDU 1*1 onto hi=0, lo=0xFFFFFFFF
    cycle(MD_MTHI, 32'h0, 32'h0, 1'b0);
    cycle(MD_MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0);
`ifdef MDU_MADD_EN
    run_op(MD_MADDU, 32'd1, 32'd1, MULT_N);
    check("maddu_hi", bus.hi, 32'd1);
    check("maddu_lo", bus.lo, 32'd0);
`else
    cycle(MD_MADDU, 32'd1, 32'd1, 1'b0);
    cycle(MD_NONE, 32'h0, 32'h0, 1'b0);
    check("maddu_off_busy", bus.busy, 1'b0);
    check("maddu_off_hi", bus.hi, 32'd0);
    check("maddu_off_lo", bus.lo, 32'hFFFF_FFFF);
`endif

    // Reset held two cycles mid-divide: no late write afterwards
    cycle(MD_MTHI, 32'h55, 32'h0, 1'b0);
    cycle(MD_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) cycle(MD_NONE, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_run_busy", bus.busy, 1'b0);
    check("rst_run_hi", bus.hi, 32'h0);
    check("rst_run_lo", bus.lo, 32'h0);
    reset = 1'b0;
    model_reset();
    repeat (12) cycle(MD_NONE, 32'h0, 32'h0, 1'($urandom_range(0, 1)));

    // Randomized traffic, including illegal-in-RUN ops and opcodes 9..15
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (left > 0) op = (r < 80) ? 4'd0 : 4'($urandom_range(1, 15));
      else          op = (r < 10) ? 4'd0 : 4'($urandom_range(1, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 40)) - 32'd20;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 6)) - 32'd3;
      if ($urandom_range(0, 9) == 0) b = 32'h0;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      cycle(op, a, b, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
